multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control sequencer for the multi-cycle rework of the MIPS datapath (shared memory, IR, A/B/ALUOut regs).
//  Decodes op/funct, steps a Moore FSM and drives every mux select, register enable and the 3-bit ALU control.
//  Sits beside the datapath in the top level; memory and datapath are slaves of this block.
// PARAMETERS
//  STATE_W    4    width of state register (12 states used; >=4 required)
//  ILLEGAL_TRAP 1  1: unknown opcode pulses illegal_op for one cycle; 0: illegal_op tied 0
// PORTS
//  clk         in   1  single system clock, all state on rising edge
//  rst         in   1  synchronous, active-high reset
//  op          in   6  instr[31:26] from IR
//  funct       in   6  instr[5:0] from IR
//  zero        in   1  ALU zero flag (combinational, same cycle)
//  iord        out  1  memory address: 0=PC, 1=ALUOut
//  memwrite    out  1  memory write strobe
//  irwrite     out  1  load IR from memory read data
//  regdst      out  1  write reg: 0=rt, 1=rd
//  memtoreg    out  1  reg write data: 0=ALUOut, 1=MDR
//  regwrite    out  1  register file write enable
//  alusrca     out  1  ALU A: 0=PC, 1=reg A
//  alusrcb     out  2  ALU B: 00=reg B, 01=4, 10=signext, 11=signext<<2
//  pcsrc       out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
//  pcen        out  1  PC load = pcwrite | (branch & zero)
//  alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegal_op  out  1  one-cycle pulse in DECODE on unsupported opcode
//  state_dbg   out  STATE_W  current state encoding (debug/verification)
// BEHAVIOUR
//  - States: FETCH(0) DECODE(1) MEMADR(2) MEMRD(3) MEMWB(4) MEMWR(5) RTYPEEX(6) RTYPEWB(7) BEQEX(8) ADDIEX(9) ADDIWB(10) JEX(11).
//  - rst=1 at clock edge -> state=FETCH; while rst=1 all outputs forced 0 (incl. pcen, irwrite, memwrite).
//  - Reset mid-instruction aborts it: no partial regwrite/memwrite after the reset edge.
//  - Moore outputs decoded from state only; pcen additionally uses zero in BEQEX.
//  - FETCH: iord=0 irwrite=1 alusrca=0 alusrcb=01 add pcsrc=00 pcen=1 -> DECODE.
//  - DECODE: alusrca=0 alusrcb=11 add (branch target into ALUOut). Next by op:
//    100011 lw / 101011 sw -> MEMADR; 000000 R -> RTYPEEX; 000100 beq -> BEQEX; 001000 addi -> ADDIEX; 000010 j -> JEX;
//    other -> FETCH, illegal_op=1 (if ILLEGAL_TRAP), no architectural side effects.
//  - MEMADR: alusrca=1 alusrcb=10 add -> MEMRD (lw) / MEMWR (sw).
//  - MEMRD: iord=1 -> MEMWB.  MEMWB: regdst=0 memtoreg=1 regwrite=1 -> FETCH.
//  - MEMWR: iord=1 memwrite=1 -> FETCH.
//  - RTYPEEX: alusrca=1 alusrcb=00, alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt,
//    other funct -> add (no trap) -> RTYPEWB.  RTYPEWB: regdst=1 memtoreg=0 regwrite=1 -> FETCH.
//  - BEQEX: alusrca=1 alusrcb=00 sub pcsrc=01; pcen=zero -> FETCH.
//  - ADDIEX: alusrca=1 alusrcb=10 add -> ADDIWB.  ADDIWB: regdst=0 memtoreg=0 regwrite=1 -> FETCH.
//  - JEX: pcsrc=10 pcen=1 -> FETCH.
//  - Cycle counts (no wait): lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
//  - Unused state encodings -> FETCH next cycle, outputs 0.
// CONFIGURATION
//  MEM_READY_EN defined: extra input mem_ready (1 bit); FETCH, MEMRD, MEMWR hold state and outputs while mem_ready=0;
//    irwrite/pcen in FETCH and memwrite in MEMWR asserted only on cycle with mem_ready=1 (write strobe once).
//  MEM_READY_EN undefined: no mem_ready port; memory completes in one cycle, timing as above.
// STRUCTURE
//  - Package mc_pkg: state enum/localparams, opcode and funct constants, ALU control codes, alusrcb/pcsrc encodings.
//  - Sub-module mc_aludec: combinational (aluop[1:0], funct) -> alucontrol; aluop 00 add, 01 sub, 10 use funct.
//  - Top holds state register, next-state logic, output decode, pcen gating.
// TESTING
//  - rst=1 two cycles with op=100011 -> all outputs 0, state_dbg=0; release -> FETCH outputs next cycle, pcen=1.
//  - lw (op=100011) -> states 0,1,2,3,4,0; regwrite=1 memtoreg=1 only in cycle 5; memwrite never 1.
//  - beq op=000100 with zero=1 -> pcen=1 pcsrc=01 in BEQEX; repeat zero=0 -> pcen=0; both 3 cycles.
//  - R-type funct=101010 -> alucontrol=111 in RTYPEEX, regdst=1 regwrite=1 in RTYPEWB; funct=100010 -> 110.
//  - op=111111 -> illegal_op=1 for exactly one DECODE cycle, back to FETCH, no regwrite/memwrite.
//  - MEM_READY_EN: sw with mem_ready low 3 cycles in MEMWR -> state held, memwrite=1 exactly one cycle; rst mid-stall -> FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, opcodes,
// funct codes, ALU control codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath/memory signal bundle. The controller is the master;
// the datapath and memory sit on the slave side. Optional mem_ready with MEM_READY_EN.
interface mc_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
`ifdef MEM_READY_EN
  // Memory handshake: an access in FETCH/MEMRD/MEMWR completes on the cycle
  // mem_ready=1; while it is 0 the controller holds state and withholds strobes.
  logic       mem_ready;
`endif
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       illegal_op;

  modport master (
    input  op, funct, zero,
`ifdef MEM_READY_EN
    input  mem_ready,
`endif
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op
  );

  modport slave (
    output op, funct, zero,
`ifdef MEM_READY_EN
    output mem_ready,
`endif
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op
  );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: aluop selects fixed add/sub or a funct-driven R-type operation.
// Unknown funct (and aluop 11) fall back to add rather than trapping.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath. Optional memory wait
// states are enabled with the MEM_READY_EN macro.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int STATE_W      = 4,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic               clk,
  input  logic               rst,
  mc_if.master               bus,
  output logic [STATE_W-1:0] state_dbg
);

  state_t     state_q, state_d;
  logic       mem_ok;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       pcwrite, branch, alu_used, illegal;
  logic [2:0] alu_dec;

`ifdef MEM_READY_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REGB;
    pcsrc    = PCSRC_ALU;
    aluop    = ALUOP_ADD;
    alu_used = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb  = SRCB_FOUR;
        alu_used = 1'b1;
        irwrite  = mem_ok;
        pcwrite  = mem_ok;
        if (mem_ok) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        alusrcb  = SRCB_BR;
        alu_used = 1'b1;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d = S_FETCH;
            illegal = (ILLEGAL_TRAP != 0);
          end
        endcase
      end
      S_MEMADR: begin
        alusrca  = 1'b1;
        alusrcb  = SRCB_IMM;
        alu_used = 1'b1;
        state_d  = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = mem_ok;
        if (mem_ok) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_FUNCT;
        alu_used = 1'b1;
        state_d  = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        alu_used = 1'b1;
        pcsrc    = PCSRC_OUT;
        branch   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca  = 1'b1;
        alusrcb  = SRCB_IMM;
        alu_used = 1'b1;
        state_d  = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (alu_dec)
  );

  // Reset masks every output so an aborted instruction cannot leave a strobe behind.
  assign bus.iord       = !rst && iord;
  assign bus.memwrite   = !rst && memwrite;
  assign bus.irwrite    = !rst && irwrite;
  assign bus.regdst     = !rst && regdst;
  assign bus.memtoreg   = !rst && memtoreg;
  assign bus.regwrite   = !rst && regwrite;
  assign bus.alusrca    = !rst && alusrca;
  assign bus.alusrcb    = rst ? 2'b00 : alusrcb;
  assign bus.pcsrc      = rst ? 2'b00 : pcsrc;
  assign bus.pcen       = !rst && (pcwrite || (branch && bus.zero));
  assign bus.alucontrol = (rst || !alu_used) ? 3'b000 : alu_dec;
  assign bus.illegal_op = !rst && illegal;
  assign state_dbg      = rst ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table with
// hand-computed outputs, plus cycle-count and wait-state sequences.
module tb_multicycle_controller;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  exp_state;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] state_dbg;
  logic [15:0] act_out;
  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          compared = 0;
  int          mismatched = 0;

  mc_if bus();

  multicycle_controller #(.STATE_W(4), .ILLEGAL_TRAP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  assign act_out = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                    bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen,
                    bus.alucontrol, bus.illegal_op};

  function automatic logic [15:0] pk(input logic iord, mw, irw, rd, mtr, rw, asa,
                                     input logic [1:0] asb, pcs,
                                     input logic pcen, input logic [2:0] alu,
                                     input logic ill);
    return {iord, mw, irw, rd, mtr, rw, asa, asb, pcs, pcen, alu, ill};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [3:0] st, input logic [15:0] out);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.exp_state = st;
    vecs.push_back(v);
    exp_q.push_back(out);
  endtask

  // Starts in FETCH right after a negedge; counts edges until FETCH returns.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int exp_cycles, input int exp_writes,
                           input int exp_ill);
    int n = 0;
    int writes = 0;
    int ills = 0;
    rst = 1'b0; bus.op = o; bus.funct = f; bus.zero = z;
    #1;
    chk({name, "_start"}, 32'(state_dbg), 32'd0);
    do begin
      if (bus.regwrite || bus.memwrite) writes++;
      if (bus.illegal_op) ills++;
      @(posedge clk); n++;
      @(negedge clk); #1;
    end while (state_dbg != 4'd0 && n < 20);
    chk({name, "_cycles"}, 32'(n), 32'(exp_cycles));
    chk({name, "_writes"}, 32'(writes), 32'(exp_writes));
    chk({name, "_illegal"}, 32'(ills), 32'(exp_ill));
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    logic [15:0] o_rst, o_fetch, o_dec, o_dec_ill, o_madr, o_mrd, o_mwb, o_mwr;
    logic [15:0] o_rtwb, o_aex, o_awb, o_jex;
    bus.op = 6'b100011; bus.funct = 6'd0; bus.zero = 1'b0;
`ifdef MEM_READY_EN
    bus.mem_ready = 1'b1;
`endif
    o_rst     = 16'd0;
    o_fetch   = pk(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,0);
    o_dec     = pk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0);
    o_dec_ill = pk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,1);
    o_madr    = pk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0);
    o_mrd     = pk(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b000,0);
    o_mwb     = pk(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b000,0);
    o_mwr     = pk(1,1,0,0,0,0,0,2'b00,2'b00,0,3'b000,0);
    o_rtwb    = pk(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b000,0);
    o_aex     = pk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0);
    o_awb     = pk(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b000,0);
    o_jex     = pk(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b000,0);

    // Reset held two cycles with lw on the IR, then a full lw.
    add_v(1, 6'b100011, 6'd0, 0, 4'd0, o_rst);
    add_v(1, 6'b100011, 6'd0, 0, 4'd0, o_rst);
    add_v(0, 6'b100011, 6'd0, 0, 4'd0, o_fetch);
    add_v(0, 6'b100011, 6'd0, 0, 4'd1, o_dec);
    add_v(0, 6'b100011, 6'd0, 0, 4'd2, o_madr);
    add_v(0, 6'b100011, 6'd0, 0, 4'd3, o_mrd);
    add_v(0, 6'b100011, 6'd0, 0, 4'd4, o_mwb);
    // sw
    add_v(0, 6'b101011, 6'd0, 0, 4'd0, o_fetch);
    add_v(0, 6'b101011, 6'd0, 0, 4'd1, o_dec);
    add_v(0, 6'b101011, 6'd0, 0, 4'd2, o_madr);
    add_v(0, 6'b101011, 6'd0, 0, 4'd5, o_mwr);
    // R-type slt, sub, and, unknown funct
    add_v(0, 6'b000000, 6'b101010, 0, 4'd0, o_fetch);
    add_v(0, 6'b000000, 6'b101010, 0, 4'd1, o_dec);
    add_v(0, 6'b000000, 6'b101010, 0, 4'd6, pk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b111,0));
    add_v(0, 6'b000000, 6'b101010, 0, 4'd7, o_rtwb);
    add_v(0, 6'b000000, 6'b100010, 0, 4'd0, o_fetch);
    add_v(0, 6'b000000, 6'b100010, 0, 4'd1, o_dec);
    add_v(0, 6'b000000, 6'b100010, 0, 4'd6, pk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b110,0));
    add_v(0, 6'b000000, 6'b100010, 0, 4'd7, o_rtwb);
    add_v(0, 6'b000000, 6'b100100, 0, 4'd0, o_fetch);
    add_v(0, 6'b000000, 6'b100100, 0, 4'd1, o_dec);
    add_v(0, 6'b000000, 6'b100100, 0, 4'd6, pk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b000,0));
    add_v(0, 6'b000000, 6'b100100, 0, 4'd7, o_rtwb);
    add_v(0, 6'b000000, 6'b100101, 0, 4'd0, o_fetch);
    add_v(0, 6'b000000, 6'b100101, 0, 4'd1, o_dec);
    add_v(0, 6'b000000, 6'b100101, 0, 4'd6, pk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b001,0));
    add_v(0, 6'b000000, 6'b100101, 0, 4'd7, o_rtwb);
    add_v(0, 6'b000000, 6'b000000, 0, 4'd0, o_fetch);
    add_v(0, 6'b000000, 6'b000000, 0, 4'd1, o_dec);
    add_v(0, 6'b000000, 6'b000000, 0, 4'd6, pk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b010,0));
    add_v(0, 6'b000000, 6'b000000, 0, 4'd7, o_rtwb);
    // addi
    add_v(0, 6'b001000, 6'd0, 0, 4'd0, o_fetch);
    add_v(0, 6'b001000, 6'd0, 0, 4'd1, o_dec);
    add_v(0, 6'b001000, 6'd0, 0, 4'd9, o_aex);
    add_v(0, 6'b001000, 6'd0, 0, 4'd10, o_awb);
    // beq taken, then not taken
    add_v(0, 6'b000100, 6'd0, 1, 4'd0, o_fetch);
    add_v(0, 6'b000100, 6'd0, 1, 4'd1, o_dec);
    add_v(0, 6'b000100, 6'd0, 1, 4'd8, pk(0,0,0,0,0,0,1,2'b00,2'b01,1,3'b110,0));
    add_v(0, 6'b000100, 6'd0, 0, 4'd0, o_fetch);
    add_v(0, 6'b000100, 6'd0, 0, 4'd1, o_dec);
    add_v(0, 6'b000100, 6'd0, 0, 4'd8, pk(0,0,0,0,0,0,1,2'b00,2'b01,0,3'b110,0));
    // j
    add_v(0, 6'b000010, 6'd0, 0, 4'd0, o_fetch);
    add_v(0, 6'b000010, 6'd0, 0, 4'd1, o_dec);
    add_v(0, 6'b000010, 6'd0, 0, 4'd11, o_jex);
    // illegal opcode
    add_v(0, 6'b111111, 6'd0, 0, 4'd0, o_fetch);
    add_v(0, 6'b111111, 6'd0, 0, 4'd1, o_dec_ill);
    // lw aborted by reset in MEMRD: no MEMWB write afterwards
    add_v(0, 6'b100011, 6'd0, 0, 4'd0, o_fetch);
    add_v(0, 6'b100011, 6'd0, 0, 4'd1, o_dec);
    add_v(0, 6'b100011, 6'd0, 0, 4'd2, o_madr);
    add_v(0, 6'b100011, 6'd0, 0, 4'd3, o_mrd);
    add_v(1, 6'b100011, 6'd0, 0, 4'd0, o_rst);
    add_v(0, 6'b100011, 6'd0, 0, 4'd0, o_fetch);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [15:0] exp_out;
      @(negedge clk);
      rst = vecs[i].rst; bus.op = vecs[i].op; bus.funct = vecs[i].funct; bus.zero = vecs[i].zero;
      #1;
      exp_out = exp_q.pop_front();
      chk($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].exp_state));
      chk($sformatf("vec%0d_outputs", i), 32'(act_out), 32'(exp_out));
    end

    do_reset();
    run_instr("lw",   6'b100011, 6'd0,      0, 5, 1, 0);
    run_instr("sw",   6'b101011, 6'd0,      0, 4, 1, 0);
    run_instr("rtyp", 6'b000000, 6'b100000, 0, 4, 1, 0);
    run_instr("addi", 6'b001000, 6'd0,      0, 4, 1, 0);
    run_instr("beq",  6'b000100, 6'd0,      1, 3, 0, 0);
    run_instr("j",    6'b000010, 6'd0,      0, 3, 0, 0);
    run_instr("ill",  6'b111111, 6'd0,      0, 2, 0, 1);

`ifdef MEM_READY_EN
    begin
      int wr_cnt = 0;
      bus.op = 6'b101011; bus.mem_ready = 1'b0;
      #1;
      chk("stall_fetch_out", 32'(act_out), 32'(pk(0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,0)));
      @(negedge clk); #1;
      chk("stall_fetch_state", 32'(state_dbg), 32'd0);
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); #1;
      end
      chk("sw_at_memwr", 32'(state_dbg), 32'd5);
      bus.mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        #1;
        if (bus.memwrite) wr_cnt++;
        @(negedge clk); #1;
        chk($sformatf("memwr_hold%0d", k), 32'(state_dbg), 32'd5);
      end
      bus.mem_ready = 1'b1;
      #1;
      if (bus.memwrite) wr_cnt++;
      chk("memwrite_once", 32'(wr_cnt), 32'd1);
      @(negedge clk); #1;
      chk("memwr_done", 32'(state_dbg), 32'd0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); #1;
      end
      chk("sw2_at_memwr", 32'(state_dbg), 32'd5);
      bus.mem_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk); #1;
      chk("rst_stall_memwrite", 32'(bus.memwrite), 32'd0);
      rst = 1'b0; bus.mem_ready = 1'b1;
      #1;
      chk("rst_stall_state", 32'(state_dbg), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
